// File: rtl/mic_sample_ctrl_if.sv
// Sample stream from mic_sample_ctrl to the audio chain: show-ahead data
// with valid/ready; a transfer happens on a cycle where both are high.
interface mic_sample_ctrl_if;
  logic [11:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;

  modport master (output smp_data, output smp_valid, input smp_ready);
  modport slave  (input smp_data, input smp_valid, output smp_ready);
endinterface

// File: rtl/mic_sample_ctrl.sv
// Paces the PmodMIC capture block, converts each 12-bit offset-binary code to
// two's complement and queues it in a show-ahead FIFO. Define MIC_DC_REMOVE_EN
// to subtract a running DC estimate from every sample before it is queued.
module mic_sample_ctrl #(
  parameter int SAMPLE_DIV = 1250,
  parameter int ADDR_W     = 4,
  parameter int DC_SHIFT   = 6
) (
  input  logic                clk_sclk,
  input  logic                rst,
  input  logic                enable,
  output logic                mic_start,
  input  logic                mic_done,
  input  logic [15:0]         mic_pData,
  mic_sample_ctrl_if.master   smp,
  output logic [ADDR_W:0]     fifo_count,
  output logic                overflow,
  input  logic                clr_ovf
);

  localparam int                DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic              r_done_q;
  logic              w_tick;
  logic              w_capture;
  logic [11:0]       w_sample;
  logic [11:0]       w_wdata;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [11:0]       r_mem [DEPTH];
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              r_overflow;
  logic              w_unused;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before the edge.
  always_ff @(posedge clk_sclk or negedge rst) begin
    if (!rst) begin
      r_div    <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + DIV_ONE;
      r_done_q <= mic_done;
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk_sclk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (mic_start) w_state_nxt = S_BUSY;
      S_BUSY: if (w_capture) w_state_nxt = S_IDLE;
    endcase
  end

  // A tick that lands while a conversion is still running is simply lost.
  always_comb begin
    mic_start = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: mic_start = w_tick && enable;
      S_BUSY: w_capture = mic_done && !r_done_q;
    endcase
  end

  assign w_sample = {~mic_pData[11], mic_pData[10:0]};

`ifdef MIC_DC_REMOVE_EN
  localparam int ACC_W = 12 + DC_SHIFT;

  logic signed [ACC_W-1:0] r_dc;
  logic signed [ACC_W:0]   w_dc_err;
  logic signed [ACC_W:0]   w_dc_sum;
  logic signed [12:0]      w_dc_diff;

  // r_dc holds the DC estimate scaled by 2^DC_SHIFT; one extra bit keeps the
  // error term from wrapping when sample and estimate sit at opposite rails.
  assign w_dc_err  = ($signed({{(DC_SHIFT + 1){w_sample[11]}}, w_sample}) <<< DC_SHIFT)
                   - $signed({r_dc[ACC_W-1], r_dc});
  assign w_dc_sum  = $signed({r_dc[ACC_W-1], r_dc}) + (w_dc_err >>> DC_SHIFT);
  assign w_dc_diff = $signed({w_sample[11], w_sample})
                   - $signed({r_dc[ACC_W-1], r_dc[ACC_W-1:DC_SHIFT]});
  assign w_wdata   = (w_dc_diff[12] != w_dc_diff[11])
                   ? {w_dc_diff[12], {11{~w_dc_diff[12]}}}
                   : w_dc_diff[11:0];

  always_ff @(posedge clk_sclk or negedge rst) begin
    if (!rst)           r_dc <= '0;
    else if (w_capture) r_dc <= w_dc_sum[ACC_W-1:0];
  end

  assign w_unused = ^{mic_pData[15:12], w_dc_sum[ACC_W]};
`else
  assign w_wdata  = w_sample;
  assign w_unused = ^{mic_pData[15:12], DC_SHIFT[0]};
`endif

  // Occupancy never exceeds DEPTH, so its MSB alone flags a full FIFO.
  assign fifo_count = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = fifo_count[ADDR_W];
  assign w_push     = w_capture && !w_full;
  assign w_pop      = !w_empty && smp.smp_ready;

  always_ff @(posedge clk_sclk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_capture && w_full) r_overflow <= 1'b1;
      else if (clr_ovf)        r_overflow <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and an empty FIFO is forced to read as zero below.
  always_ff @(posedge clk_sclk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wdata;
  end

  assign smp.smp_data  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign smp.smp_valid = !w_empty;
  assign overflow      = r_overflow;

endmodule

// File: doc/mic_sample_ctrl.md
Name: mic_sample_ctrl

Overview:
- Sits directly downstream of the PmodMIC serial capture block, and also paces it.
- Issues periodic one-cycle start pulses at the audio sample rate.
- On each completed conversion, extracts the 12-bit ADC code from the 16-bit shift word and converts it to two's complement.
- Buffers the samples in a small show-ahead FIFO with a valid/ready read interface for the audio processing chain.

Parameters:
- SAMPLE_DIV, 1250: clk_sclk cycles between start pulses; legal range ≥ 20.
- ADDR_W, 4: FIFO address width; depth = 2^ADDR_W entries.
- DC_SHIFT, 6: IIR time-constant shift. Used only with the optional feature.

Ports:
- clk_sclk  in  1: system/serial clock, same clock that drives the capture block.
- rst  in  1: asynchronous, active-low reset.
- enable  in  1: allow new start pulses.
- mic_start  out  1: one-cycle start pulse to the capture block.
- mic_done  in  1: done level from the capture FSM. Its rising edge marks mic_pData as valid.
- mic_pData  in  16: shifted word; bits [11:0] hold the ADC code (offset binary).
- smp_data  out  12: signed two's-complement sample at the FIFO head.
- smp_valid  out  1: FIFO not empty.
- smp_ready  in  1: consumer accepts the head when smp_valid && smp_ready.
- fifo_count  out  ADDR_W+1: number of entries stored, 0..2^ADDR_W.
- overflow  out  1: sticky; a sample was dropped because the FIFO was full.
- clr_ovf  in  1: clears overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0: mic_start=0, smp_valid=0, smp_data=0 (empty FIFO reads as 0), fifo_count=0, overflow=0.
  - Divider=0, busy=0, done_q=0, FIFO pointers=0.
  - Reset mid-conversion abandons the in-flight capture; a later mic_done edge while busy=0 is ignored.
- Divider:
  - Counts 0..SAMPLE_DIV-1 and wraps; runs continuously regardless of enable.
  - At count==SAMPLE_DIV-1 with enable=1 and busy=0: mic_start=1 for exactly that cycle, and busy is set.
  - If busy=1 at that cycle, no pulse is issued; there is no catch-up.
- Done detection:
  - done_q registers mic_done.
  - capture = mic_done && !done_q && busy.
  - On capture, busy clears in the same cycle.
  - Deasserting enable mid-conversion does not cancel it; the sample is still captured.
- Conversion:
  - sample = {~mic_pData[11], mic_pData[10:0]}.
  - Example mappings: 0x800→0x000, 0xFFF→0x7FF, 0x000→0x800.
  - mic_pData[15:12] are ignored.
- FIFO write:
  - On a capture cycle the sample is written at the clock edge ending that cycle.
  - smp_valid rises in the next cycle if the FIFO was empty (1-cycle latency from the done edge).
- FIFO read:
  - Show-ahead: smp_data = mem[rd_ptr], combinational from registered pointers.
  - A pop occurs on smp_valid && smp_ready.
  - smp_ready while empty has no effect.
- Full:
  - The full decision uses pre-cycle occupancy. A write while full is dropped even if a pop occurs in the same cycle.
  - A dropped write sets overflow.
- Simultaneous push and pop (not full, not empty): fifo_count unchanged, both pointers advance.
- Pointers: ADDR_W+1 bits each, wrap naturally; fifo_count = wr_ptr - rd_ptr.
- overflow: clr_ovf clears it; a set event in the same cycle wins.

Optional Feature:
- Macro: MIC_DC_REMOVE_EN.
- When defined:
  - A signed accumulator dc (12+DC_SHIFT bits, reset 0) tracks the DC offset.
  - On each capture: dc <= dc + (sample<<<DC_SHIFT - dc)>>>DC_SHIFT, using an arithmetic shift.
  - The written value is sat12(sample - dc[11+DC_SHIFT:DC_SHIFT]), computed from the pre-update dc and saturated to -2048..2047.
  - dc updates even when the write is dropped as an overflow.
  - Latency is unchanged.
- When undefined: the raw converted sample is written and no accumulator exists.

Test Plan:
- Reset/idle: rst low for 5 cycles then high, enable=0 for 100 cycles → mic_start never asserts; smp_valid=0, fifo_count=0, overflow=0.
- Pacing (SAMPLE_DIV=20), with the capture model raising done 18 cycles after start:
  - enable=1 → mic_start pulses exactly every 20 cycles, each one cycle wide.
  - Same setup with done delayed 25 cycles → every other pulse is skipped.
- Conversion: model returns pData 0x0800, 0x0FFF, 0xF000, 0x0123 → smp_data pops 0x000, 0x7FF, 0x800, 0x923; smp_valid is high 1 cycle after each done edge.
- Full/overflow (ADDR_W=2, smp_ready=0):
  - 5 captures → fifo_count=4 and overflow=1; draining returns only the first 4 samples in order.
  - Pulse clr_ovf coincident with a 6th dropped write → overflow stays 1.
- Simultaneous push/pop:
  - fifo_count=2, capture with smp_ready=1 in the same cycle → fifo_count stays 2 and FIFO order is preserved.
  - When full, the same stimulus → write dropped and count becomes 3.
- Reset mid-operation / DC removal:
  - Assert rst with busy=1 and fifo_count=3 → all cleared; the stray done edge after release is ignored.
  - With MIC_DC_REMOVE_EN, DC_SHIFT=2 and a constant input of 0x0C00 (sample 0x400) → the written value decays toward 0 within 40 samples.
